aes_key_sched_iter: RTL and testbench
=====================================

Name: aes_key_sched_iter

Overview:
Iterative, multi-mode AES key scheduler. It supports AES-128, AES-192 and AES-256, selected at run time.
It expands a cipher key into all round keys at one 32-bit word per clock and holds them in an internal word store. The encrypt/decrypt datapath reads any round key by index.
It replaces the fully combinational 128-only expansion in the add_round_key path, trading latency for area.

Parameters:
MAX_NK, 8, largest key length supported in 32-bit words (4, 6 or 8). Word store depth = 4*(MAX_NK+7).
OUT_REG, 1, 1 = rk_out registered (1-cycle read latency); 0 = rk_out combinational from rk_idx.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to expand key_in; sampled only in IDLE
key_len  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
key_in  in  256  cipher key, MSB-aligned: w0=key_in[255:224], w1=[223:192], ...; unused low bits ignored
busy  out  1  high from the start-accept edge until the done edge
done  out  1  one-cycle pulse when the last word is written
ready  out  1  level; round keys valid; cleared by the next accepted start
err  out  1  level; last start had an illegal key_len; cleared by the next legal start
nr_out  out  4  Nr of the held schedule (10/12/14); 0 when ready=0
rk_idx  in  4  round-key index to read, 0..Nr
rk_out  out  128  round key rk_idx = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in [127:96]

Behaviour:
- Reset (async assert, sync-style release): state=IDLE; busy, done, ready, err, nr_out and rk_out all 0. Word store is not cleared.
- Mode decode:
  - Nk = 4/6/8 and Nr = 10/12/14 for key_len 00/01/10.
  - Total words T = 4*(Nr+1) = 44/52/60.
  - key_len=11, or Nk>MAX_NK, is illegal.
- FSM IDLE -> LOAD -> EXPAND -> IDLE:
  - IDLE: on start with legal key_len, latch Nk/Nr, clear ready, set busy, go to LOAD.
  - IDLE, illegal start: set err at that edge, stay IDLE; ready and held keys are unchanged.
  - LOAD (1 cycle): write w0..w[Nk-1] from key_in. Initialise i=Nk, phase counter j=0 (i mod Nk), rcon=8'h01.
  - EXPAND, one word per cycle:
    - temp = w[i-1].
    - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, and rcon advances by xtime (0x80 -> 0x1B).
    - Else if Nk==8 and j==4: temp = SubWord(temp).
    - w[i] = w[i-Nk] ^ temp; i++; j wraps at Nk.
    - After w[T-1] is written, go to IDLE.
- Use a modulo counter, not a divider. SubWord uses 4 combinational S-box instances.
- Timing: start accepted at edge k. done, ready and nr_out rise and busy falls at edge k+L, where L = 2+T-Nk = 42/48/54. done falls at k+L+1.
- start while busy: ignored; no effect on the running expansion.
- start on the same edge that done rises: ignored (state is not yet IDLE).
- Read path:
  - rk_out = 0 if ready=0 or rk_idx>nr_out.
  - OUT_REG=1: rk_out reflects the rk_idx sampled at the previous edge.
  - OUT_REG=0: rk_out reflects the current rk_idx.
- Reset mid-expansion: immediate IDLE; ready=0, busy=0, no done pulse.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done 42 cycles after start. rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; nr_out=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (MSB-aligned) -> done at 48 cycles; rk_idx=12 gives e98ba06f448c773c8ecc720401002202; rk_idx=13 gives 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done at 54 cycles; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e.
- key_len=11 with start -> err=1 next edge, busy stays 0, no done, previously held keys still readable. A following legal start clears err.
- Second start pulsed at cycle 10 of an AES-128 run -> ignored; done still at 42 with the first key's schedule. Sampling rk_idx=0 while busy returns 0.
- rst_n low at cycle 20 of an AES-256 run -> all outputs 0 asynchronously. A new AES-128 start after release completes normally in 42 cycles.

Source files
------------

// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter: iterative AES-128/192/256 key expansion.
// Expands key_in into 4*(Nr+1) words, one word per clock, into a word store.
// Any round key can then be read by index.
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, key_len    expansion request (sampled in IDLE), mode 00/01/10
//   key_in            cipher key, MSB-aligned (w0 = key_in[255:224])
//   busy, done        expansion in flight / one-cycle completion pulse
//   ready, err        schedule valid / last start had an illegal key_len
//   nr_out            Nr of the held schedule, 0 while not ready
//   rk_idx, rk_out    round-key read port

// AES forward S-box, table entry 0 sits in the top byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // 255-a == ~a, so the entry for a lives at bit offset 8*~a
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_key_sched_iter #(
  parameter int MAX_NK  = 8,
  parameter bit OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic         err,
  output logic [3:0]   nr_out,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);
  localparam int DEPTH = 4*(MAX_NK+7);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND} state_e;
  state_e state_q, state_d;

  logic [3:0]  nk_dec, nr_dec, nk_q, nr_q;
  logic [5:0]  i_q, t_q;
  logic [2:0]  j_q;
  logic [7:0]  rcon_q;
  logic        busy_q, done_q, ready_q, err_q;
  logic        legal, accept, last, wr_en;
  logic [31:0] ws [DEPTH];
  logic [31:0] prev_w, old_w, sub_in, sub_out, temp, new_w;

  always_comb begin
    nk_dec = 4'd4;
    nr_dec = 4'd10;
    case (key_len)
      2'b01:   begin nk_dec = 4'd6; nr_dec = 4'd12; end
      2'b10:   begin nk_dec = 4'd8; nr_dec = 4'd14; end
      default: ;
    endcase
  end

  assign legal  = (key_len != 2'b11) && (int'(nk_dec) <= MAX_NK);
  assign accept = (state_q == S_IDLE) && start && legal;
  // i reaches T one cycle after the final write; that cycle retires the run
  assign last   = (state_q == S_EXPAND) && (i_q == t_q);
  assign wr_en  = (state_q == S_EXPAND) && !last;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LOAD;
      S_LOAD:   state_d = S_EXPAND;
      S_EXPAND: if (last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nk_q <= '0; nr_q <= '0; t_q <= '0; i_q <= '0; j_q <= '0;
      rcon_q <= 8'h01;
      busy_q <= 1'b0; done_q <= 1'b0; ready_q <= 1'b0; err_q <= 1'b0;
    end else begin
      done_q <= last;
      if (state_q == S_IDLE && start) err_q <= !legal;
      if (accept) begin
        nk_q    <= nk_dec;
        nr_q    <= nr_dec;
        t_q     <= {nr_dec, 2'b00} + 6'd4;
        ready_q <= 1'b0;
        busy_q  <= 1'b1;
      end
      if (state_q == S_LOAD) begin
        i_q    <= {2'b00, nk_q};
        j_q    <= '0;
        rcon_q <= 8'h01;
      end
      if (wr_en) begin
        i_q <= i_q + 6'd1;
        j_q <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      end
      if (last) begin
        busy_q  <= 1'b0;
        ready_q <= 1'b1;
      end
    end
  end

  // Expansion datapath: w[i] = w[i-Nk] ^ f(w[i-1])
  assign prev_w = ws[i_q - 6'd1];
  assign old_w  = ws[i_q - {2'b00, nk_q}];
  assign sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  always_comb begin
    temp = prev_w;
    if (j_q == 3'd0)                          temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && j_q == 3'd4)     temp = sub_out;
  end
  assign new_w = old_w ^ temp;

  // Word store is deliberately not reset; ready gates every read.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      for (int k = 0; k < MAX_NK; k++)
        if (k < int'(nk_q)) ws[k] <= key_in[255-32*k -: 32];
    end else if (wr_en) begin
      ws[i_q] <= new_w;
    end
  end

  // Read path
  logic [5:0]   ra;
  logic         idx_ok;
  logic [127:0] rk_comb;
  assign ra      = {rk_idx, 2'b00};
  assign idx_ok  = ready_q && (rk_idx <= nr_q);
  assign rk_comb = idx_ok ? {ws[ra], ws[ra+6'd1], ws[ra+6'd2], ws[ra+6'd3]} : '0;

  if (OUT_REG) begin : g_oreg
    logic [127:0] rk_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rk_q <= '0;
      else        rk_q <= rk_comb;
    assign rk_out = rk_q;
  end else begin : g_ocomb
    assign rk_out = rk_comb;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ready  = ready_q;
  assign err    = err_q;
  assign nr_out = ready_q ? nr_q : 4'd0;
endmodule

// File: tb/tb_aes_key_sched_iter.sv
module tb_aes_key_sched_iter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key_in = '0;
  logic [3:0]   rk_idx = '0;
  logic         busy, done, ready, err;
  logic [3:0]   nr_out;
  logic [127:0] rk_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [255:0] K128 =
    256'h2b7e151628aed2a6abf7158809cf4f3c_a5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
  localparam logic [255:0] K192 =
    256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b_deadbeef_01234567;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_sched_iter #(.MAX_NK(8), .OUT_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .ready(ready), .err(err), .nr_out(nr_out),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // read round key idx (registered port: value visible after the next edge)
  task automatic rd(input logic [3:0] idx, input string tag, input logic [127:0] exp);
    @(negedge clk); rk_idx = idx;
    @(posedge clk); #1;
    chk(tag, rk_out, exp);
  endtask

  // pulse start so it is sampled at the next rising edge; returns at edge+1ns
  task automatic go(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    key_len = kl; key_in = k; rk_idx = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // count edges after the accept edge until done; n=0 if lim reached first.
  // inj_at: cycle after which a stray start (other key, AES-256) is pulsed.
  task automatic wait_done(input int lim, input int inj_at, output int n);
    n = 0;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk); #1;
      if (c == 5) chk("rd_while_busy", rk_out, 128'h0);
      if (done) begin n = c; break; end
      if (c == inj_at) begin key_len = 2'b10; key_in = K256; start = 1'b1; end
      if (c == inj_at + 1) start = 1'b0;
    end
  endtask

  int n;
  int cnt;

  initial begin
    // reset state
    #3 rst_n = 1'b0;
    #1;
    chk("rst_outs", {busy, done, ready, err, nr_out}, '0);
    chk("rst_rk", rk_out, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // AES-128
    go(2'b00, K128);
    chk("a128_busy", {busy, ready}, 2'b10);
    wait_done(100, 0, n);
    chk("a128_lat", n, 42);
    chk("a128_flags", {busy, ready, nr_out}, {1'b0, 1'b1, 4'd10});
    @(posedge clk); #1;
    chk("a128_done_fall", done, 1'b0);
    rd(4'd0,  "a128_rk0",  128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd(4'd1,  "a128_rk1",  128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, "a128_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd11, "a128_rk11", 128'h0);

    // AES-192
    go(2'b01, K192);
    chk("a192_ready_clr", ready, 1'b0);
    wait_done(100, 0, n);
    chk("a192_lat", n, 48);
    chk("a192_nr", nr_out, 4'd12);
    rd(4'd0,  "a192_rk0",  128'h8e73b0f7da0e6452c810f32b809079e5);
    rd(4'd1,  "a192_rk1",  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    rd(4'd12, "a192_rk12", 128'he98ba06f448c773c8ecc720401002202);
    rd(4'd13, "a192_rk13", 128'h0);

    // AES-256
    go(2'b10, K256);
    wait_done(100, 0, n);
    chk("a256_lat", n, 54);
    chk("a256_nr", nr_out, 4'd14);
    rd(4'd1,  "a256_rk1",  128'h1f352c073b6108d72d9810a30914dff4);
    rd(4'd2,  "a256_rk2",  128'h9ba354118e6925afa51a8b5f2067fcde);
    rd(4'd14, "a256_rk14", 128'hfe4890d1e6188d0b046df344706c631e);

    // illegal key_len: err set, nothing else moves, held keys stay readable
    go(2'b11, K128);
    chk("ill_err", {err, busy, ready}, 3'b101);
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    chk("ill_quiet", cnt, 0);
    chk("ill_nr", nr_out, 4'd14);
    rd(4'd14, "ill_rk14", 128'hfe4890d1e6188d0b046df344706c631e);

    // legal start clears err; stray start mid-run is ignored
    go(2'b00, K128);
    chk("clr_err", {err, busy, ready}, 3'b010);
    wait_done(100, 10, n);
    chk("inj_lat", n, 42);
    chk("inj_nr", nr_out, 4'd10);
    rd(4'd10, "inj_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // reset mid AES-256 run
    go(2'b10, K256);
    wait_done(20, 0, n);
    chk("rst_mid_nodone", n, 0);
    chk("rst_mid_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {busy, done, ready, err, nr_out}, '0);
    chk("rst_mid_rk", rk_out, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    go(2'b00, K128);
    wait_done(100, 0, n);
    chk("post_rst_lat", n, 42);
    rd(4'd10, "post_rst_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // async reset with a valid schedule on the port clears rk_out at once
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready_rk", rk_out, '0);
    chk("rst_ready_flags", {ready, nr_out}, '0);
    @(negedge clk); rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
